// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG tile transmit path.
package trng_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned DROP_W_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK_LOW
    } hs_state_t;

endpackage

// File: rtl/trng_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module trng_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/trng_byte_tx.sv
// Von Neumann debiasing sampler, byte packer, byte FIFO and 4-phase
// req/ack handshake toward the external host.
module trng_byte_tx
    import trng_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned DROP_W     = DROP_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          raw_bit,
    input  logic                          sample_tick,
    input  logic                          host_ack,
    output logic [BYTE_W-1:0]             data_out,
    output logic                          data_req,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]             drop_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    logic raw_s;
    logic ack_s;

    logic phase_q, phase_d;
    logic first_q, first_d;
    logic [BYTE_W-2:0] shreg_q, shreg_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic emit;
    logic dbit;

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] level;
    logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic [BYTE_W-1:0] push_byte;
    logic push_req, push, pop;
    logic [DROP_W-1:0] drop_q, drop_d;

    hs_state_t         state_q;
    logic [BYTE_W-1:0] data_out_q;
    logic              data_req_q;

    trng_sync2 u_sync_raw (.clk(clk), .rst(rst), .d(raw_bit),  .q(raw_s));
    trng_sync2 u_sync_ack (.clk(clk), .rst(rst), .d(host_ack), .q(ack_s));

    always_comb begin
        phase_d = phase_q;
        first_d = first_q;
        emit    = 1'b0;
        dbit    = first_q;
        if (!en) begin
            phase_d = 1'b0;
        end else if (sample_tick) begin
            if (!phase_q) begin
                first_d = raw_s;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                emit    = (first_q != raw_s);
            end
        end

        shreg_d   = shreg_q;
        bcnt_d    = bcnt_q;
        push_req  = 1'b0;
        push_byte = {shreg_q, dbit};
        if (emit) begin
            shreg_d  = {shreg_q[BYTE_W-3:0], dbit};
            bcnt_d   = bcnt_q + 3'd1;
            push_req = (bcnt_q == 3'd7);
        end
    end

    // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
    always_comb begin
        level  = wptr_q - rptr_q;
        pop    = (state_q == IDLE) && (level != '0) && !ack_s;
        push   = push_req && (pop || (level != FULL_LVL));
        wptr_d = wptr_q + (AW+1)'(push);
        rptr_d = rptr_q + (AW+1)'(pop);
        drop_d = drop_q;
        if (push_req && !push && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            first_q <= 1'b0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            drop_q  <= '0;
        end else begin
            phase_q <= phase_d;
            first_q <= first_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wptr_q[AW-1:0]] <= push_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_out_q <= '0;
            data_req_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        data_out_q <= mem_q[rptr_q[AW-1:0]];
                        data_req_q <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        data_req_q <= 1'b0;
                        state_q    <= ACK_LOW;
                    end
                end
                ACK_LOW: begin
                    if (!ack_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_req   = data_req_q;
    assign fifo_level = level;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_trng_byte_tx.sv
// Scoreboard bench for trng_byte_tx: expected bytes are queued as they are
// produced and retired as the host side acknowledges them.
module tb_trng_byte_tx;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       raw_bit;
    logic       sample_tick;
    logic       host_ack;
    logic [7:0] data_out;
    logic       data_req;
    logic [2:0] fifo_level;
    logic [7:0] drop_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  exp_q[$];
    int unsigned exp_drop = 0;

    trng_byte_tx #(.FIFO_DEPTH(DEPTH), .DROP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .raw_bit    (raw_bit),
        .sample_tick(sample_tick),
        .host_ack   (host_ack),
        .data_out   (data_out),
        .data_req   (data_req),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int unsigned sz;
        sz = exp_q.size();
        check({tag, "_req"}, 32'(data_req), (sz > 0) ? 32'd1 : 32'd0);
        if (sz > 0) check({tag, "_data"}, 32'(data_out), 32'(exp_q[0]));
        check({tag, "_level"}, 32'(fifo_level), (sz > 0) ? 32'(sz - 1) : 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
    endtask

    task automatic sample(input logic b);
        raw_bit = b;
        repeat (3) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        sample(b);
        sample(!b);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH + 1) exp_q.push_back(b);
        else if (exp_drop < 255) exp_drop++;
    endtask

    task automatic produce(input logic [7:0] b);
        send_bits(b, 8);
        repeat (3) @(negedge clk);
        model_push(b);
    endtask

    task automatic ack_one();
        int k;
        host_ack = 1'b1;
        k = 0;
        while (data_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ack_timeout", 32'(data_req), 32'd0);
        host_ack = 1'b0;
        repeat (6) @(negedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; raw_bit = 1'b0; sample_tick = 1'b0; host_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_state("reset");
        check("reset_data_out", 32'(data_out), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);

        // Single byte 0xB1 and ack-to-req-fall latency
        produce(8'hB1);
        check_state("single");
        host_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("ack_lat_2", 32'(data_req), 32'd1);
        @(negedge clk);
        check("ack_lat_3", 32'(data_req), 32'd0);
        host_ack = 1'b0;
        repeat (6) @(negedge clk);
        void'(exp_q.pop_front());
        check_state("single_done");

        // Equal pairs are discarded without disturbing the partial byte
        send_bits(8'h0A, 4);
        for (int i = 0; i < 16; i++) begin
            sample(1'(i % 2));
            sample(1'(i % 2));
        end
        repeat (3) @(negedge clk);
        check_state("equal");
        send_bits(8'h05, 4);
        repeat (3) @(negedge clk);
        model_push(8'hA5);
        check_state("equal_byte");
        ack_one();
        check_state("equal_done");

        // Overflow with a silent host
        produce(8'h11); produce(8'h22); produce(8'h33);
        produce(8'h44); produce(8'h55); produce(8'h66);
        check_state("ovf");
        ack_one();
        check_state("ovf_ack");
        produce(8'h77);
        check_state("ovf_refill");
        for (int i = 0; i < 6 && exp_q.size() > 0; i++) begin
            ack_one();
            check_state("ovf_drain");
        end

        // Drop counter saturation
        for (int i = 0; i < 305; i++) produce(8'(i));
        check_state("sat");
        produce(8'hEE);
        check_state("sat_hold");
        for (int i = 0; i < 6 && exp_q.size() > 0; i++) begin
            ack_one();
            check_state("sat_drain");
        end

        // Enable gating mid-pair: stale first sample must be forgotten
        send_bits(8'h05, 3);
        sample(1'b1);
        en = 1'b0;
        sample(1'b0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        sample(1'b0);
        sample(1'b1);
        send_bits(8'h0C, 4);
        repeat (3) @(negedge clk);
        model_push(8'hAC);
        check_state("gate");
        ack_one();
        check_state("gate_done");

        // Reset during REQ with bytes queued
        produce(8'hC1); produce(8'hC2); produce(8'hC3);
        check_state("pre_rst");
        rst = 1'b1;
        host_ack = 1'b1;
        @(negedge clk);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        send_bits(8'h5A, 8);
        repeat (3) @(negedge clk);
        check("post_rst_req_held", 32'(data_req), 32'd0);
        check("post_rst_level", 32'(fifo_level), 32'd1);
        host_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_req_2", 32'(data_req), 32'd0);
        @(negedge clk);
        check("post_rst_req_3", 32'(data_req), 32'd1);
        exp_q.push_back(8'h5A);
        check_state("post_rst");
        ack_one();
        check_state("post_rst_done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
